// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared definitions for the memory-mapped LED PWM controller.
//   - Register byte offsets (word-aligned, low two bits ignored by decode).
//   - led_mode_e: per-LED mode encoding held in the MODE register.
//   - be_to_mask: expands bus byte enables into a 32-bit bit mask.
package led_pwm_pkg;

   localparam int unsigned ModeWidth = 2;

   localparam logic [7:0] OffCtrl  = 8'h00;
   localparam logic [7:0] OffPresc = 8'h04;
   localparam logic [7:0] OffMode  = 8'h08;
   localparam logic [7:0] OffBlink = 8'h0C;
   localparam logic [7:0] OffDuty  = 8'h40;

   typedef enum logic [ModeWidth-1:0] {
      LedOff   = 2'd0,
      LedOn    = 2'd1,
      LedPwm   = 2'd2,
      LedBlink = 2'd3
   } led_mode_e;

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      logic [31:0] mask;
      for (int i = 0; i < 4; i++) begin
         mask[8*i +: 8] = {8{be[i]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/led_pwm_if.sv
// led_pwm_if: core data-bus port of the LED controller.
//   req_i/we_i/be_i/addr_i/wdata_i : request from the bus master
//   gnt_o                          : grant, same cycle as req_i
//   rvalid_o/rdata_o/err_o         : response, one cycle after the request
// Signal suffixes are from the slave's point of view.
interface led_pwm_if;

   logic        req_i;
   logic        gnt_o;
   logic        we_i;
   logic [3:0]  be_i;
   logic [7:0]  addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;

   modport master (
      output req_i, we_i, be_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, be_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );

endinterface

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED output stage.
//   clk_sys, rst_sys_n : clock, asynchronous active-low reset
//   i_en               : global enable; forces the LED off when low
//   i_mode             : off / on / PWM / blink
//   i_duty             : programmed duty, copied to the shadow on i_frame
//   i_frame            : PWM counter wrap cycle
//   i_pwm_cnt          : shared PWM counter
//   i_phase            : blink phase (tied low when blink is not built)
//   o_led              : registered LED drive
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int unsigned CntWidth = 8
) (
   input  logic                clk_sys,
   input  logic                rst_sys_n,
   input  logic                i_en,
   input  led_mode_e           i_mode,
   input  logic [CntWidth-1:0] i_duty,
   input  logic                i_frame,
   input  logic [CntWidth-1:0] i_pwm_cnt,
   input  logic                i_phase,
   output logic                o_led
);

   logic [CntWidth-1:0] r_shadow;
   logic                r_led;
   logic                w_pwm_on;
   logic                w_led_d;

   // Duty is only sampled at the frame wrap so a period is never cut short.
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_shadow <= '0;
      end else if (i_frame) begin
         r_shadow <= i_duty;
      end
   end

   // All-ones duty means fully on, otherwise the top count would be dark.
   assign w_pwm_on = (&r_shadow) | (i_pwm_cnt < r_shadow);

   always_comb begin
      w_led_d = 1'b0;
      if (i_en) begin
         case (i_mode)
            LedOff:   w_led_d = 1'b0;
            LedOn:    w_led_d = 1'b1;
            LedPwm:   w_led_d = w_pwm_on;
            LedBlink: w_led_d = i_phase & w_pwm_on;
            default:  w_led_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_led <= 1'b0;
      end else begin
         r_led <= w_led_d;
      end
   end

   assign o_led = r_led;

endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: memory-mapped LED controller on the core data bus.
//   clk_sys, rst_sys_n : system clock, asynchronous active-low reset
//   bus                : led_pwm_if slave port (req/gnt, we, be, addr, wdata, rvalid, rdata, err)
//   led_o              : NumLeds active-high LED outputs, registered
// Optional feature macro LED_PWM_BLINK_EN builds the BLINK register, frame counter and
// blink phase; without it MODE=3 is dark and BLINK reads as zero without error.
module led_pwm_ctrl
   import led_pwm_pkg::*;
#(
   parameter int unsigned NumLeds    = 4,
   parameter int unsigned CntWidth   = 8,
   parameter int unsigned PrescWidth = 16
) (
   input  logic               clk_sys,
   input  logic               rst_sys_n,
   led_pwm_if.slave           bus,
   output logic [NumLeds-1:0] led_o
);

   localparam int unsigned DutyIdxW = (NumLeds > 1) ? $clog2(NumLeds) : 1;
   localparam int unsigned ModeRegW = ModeWidth * NumLeds;

   logic                  r_en;
   logic [PrescWidth-1:0] r_presc;
   logic [ModeRegW-1:0]   r_mode;
   logic [CntWidth-1:0]   r_duty [NumLeds];
   logic                  r_rvalid;
   logic                  r_err;
   logic [31:0]           r_rdata;
   logic [PrescWidth-1:0] r_presc_cnt;
   logic [CntWidth-1:0]   r_pwm_cnt;
`ifdef LED_PWM_BLINK_EN
   logic [15:0]           r_blink;
   logic [15:0]           r_frame_cnt;
   logic                  r_phase;
`endif

   logic [5:0]            w_word;
   logic                  w_hit_ctrl, w_hit_presc, w_hit_mode, w_hit_blink, w_hit_duty;
   logic                  w_mapped;
   logic [DutyIdxW-1:0]   w_duty_idx;
   logic [31:0]           w_rd_val;
   logic [31:0]           w_mask;
   logic [31:0]           w_wr_val;
   logic                  w_wr_en;
   logic                  w_tick;
   logic                  w_frame;
   logic                  w_phase;
   logic                  w_unused;

   // ---------------- Address decode ----------------
   assign w_word      = bus.addr_i[7:2];
   assign w_hit_ctrl  = (w_word == OffCtrl[7:2]);
   assign w_hit_presc = (w_word == OffPresc[7:2]);
   assign w_hit_mode  = (w_word == OffMode[7:2]);
   assign w_hit_blink = (w_word == OffBlink[7:2]);
   // DUTY window is 16 words; only the first NumLeds are backed by registers.
   assign w_hit_duty  = (w_word[5:4] == OffDuty[7:6]) && (32'(w_word[3:0]) < NumLeds);
   assign w_duty_idx  = w_word[DutyIdxW-1:0];
   assign w_mapped    = w_hit_ctrl | w_hit_presc | w_hit_mode | w_hit_blink | w_hit_duty;

   always_comb begin
      w_rd_val = '0;
      if (w_hit_ctrl)  w_rd_val[0] = r_en;
      if (w_hit_presc) w_rd_val[PrescWidth-1:0] = r_presc;
      if (w_hit_mode)  w_rd_val[ModeRegW-1:0] = r_mode;
`ifdef LED_PWM_BLINK_EN
      if (w_hit_blink) w_rd_val[15:0] = r_blink;
`endif
      if (w_hit_duty)  w_rd_val[CntWidth-1:0] = r_duty[w_duty_idx];
   end

   // Byte-masked merge over the current value; unimplemented bits fall away on truncation.
   assign w_mask   = be_to_mask(bus.be_i);
   assign w_wr_val = (w_rd_val & ~w_mask) | (bus.wdata_i & w_mask);
   assign w_wr_en  = bus.req_i & bus.we_i & w_mapped;
   assign w_unused = ^{bus.addr_i[1:0], w_wr_val};

   // ---------------- Registers ----------------
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_en    <= 1'b0;
         r_presc <= '0;
         r_mode  <= '0;
         for (int i = 0; i < NumLeds; i++) begin
            r_duty[i] <= '0;
         end
      end else if (w_wr_en) begin
         if (w_hit_ctrl)  r_en    <= w_wr_val[0];
         if (w_hit_presc) r_presc <= w_wr_val[PrescWidth-1:0];
         if (w_hit_mode)  r_mode  <= w_wr_val[ModeRegW-1:0];
         if (w_hit_duty)  r_duty[w_duty_idx] <= w_wr_val[CntWidth-1:0];
      end
   end

   // ---------------- Bus response ----------------
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= bus.req_i;
         r_err    <= bus.req_i & ~w_mapped;
         r_rdata  <= (bus.req_i && !bus.we_i && w_mapped) ? w_rd_val : '0;
      end
   end

   assign bus.gnt_o    = bus.req_i;
   assign bus.rvalid_o = r_rvalid;
   assign bus.err_o    = r_err;
   assign bus.rdata_o  = r_rdata;

   // ---------------- Prescaler and PWM counter ----------------
   // >= keeps the prescaler from running the full counter range if PRESC shrinks mid-count.
   assign w_tick  = r_en && (r_presc_cnt >= r_presc);
   assign w_frame = w_tick && (&r_pwm_cnt);

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_presc_cnt <= '0;
         r_pwm_cnt   <= '0;
      end else if (!r_en) begin
         r_presc_cnt <= '0;
         r_pwm_cnt   <= '0;
      end else begin
         r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PrescWidth'(1);
         if (w_tick) r_pwm_cnt <= r_pwm_cnt + CntWidth'(1);
      end
   end

   // ---------------- Blink ----------------
`ifdef LED_PWM_BLINK_EN
   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_blink <= '0;
      end else if (w_wr_en && w_hit_blink) begin
         r_blink <= w_wr_val[15:0];
      end
   end

   always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (!r_en) begin
         r_frame_cnt <= '0;
         r_phase     <= 1'b0;
      end else if (w_frame) begin
         if (r_frame_cnt == r_blink) begin
            r_frame_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign w_phase = r_phase;
`else
   assign w_phase = 1'b0;
`endif

   // ---------------- Channels ----------------
   for (genvar gi = 0; gi < NumLeds; gi++) begin : g_ch
      led_pwm_channel #(
         .CntWidth (CntWidth)
      ) u_ch (
         .clk_sys   (clk_sys),
         .rst_sys_n (rst_sys_n),
         .i_en      (r_en),
         .i_mode    (led_mode_e'(r_mode[ModeWidth*gi +: ModeWidth])),
         .i_duty    (r_duty[gi]),
         .i_frame   (w_frame),
         .i_pwm_cnt (r_pwm_cnt),
         .i_phase   (w_phase),
         .o_led     (led_o[gi])
      );
   end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// tb_led_pwm_ctrl: self-checking bench for led_pwm_ctrl (NumLeds=4, CntWidth=8, PrescWidth=16).
// Honours LED_PWM_BLINK_EN the same way as the design.
module tb_led_pwm_ctrl;

   localparam int unsigned NumLeds = 4;

   logic               clk_sys   = 1'b0;
   logic               rst_sys_n = 1'b0;
   logic [NumLeds-1:0] led_o;

   always #5 clk_sys = ~clk_sys;

   led_pwm_if bus_if ();

   led_pwm_ctrl #(
      .NumLeds    (NumLeds),
      .CntWidth   (8),
      .PrescWidth (16)
   ) dut (
      .clk_sys   (clk_sys),
      .rst_sys_n (rst_sys_n),
      .bus       (bus_if),
      .led_o     (led_o)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model state
   logic [31:0] dm [NumLeds];
   int          d_a;
   int          s_init;
   int          sch_e [4];
   int          sch_v [4];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic pwm_on(input int s, input int p);
      return (s == 255) || (p < s);
   endfunction

   // Shadow for frame f: last DUTY[0] value written at an edge strictly before the frame start.
   function automatic int shadow_for(input int f);
      int v;
      if (f == 0) return s_init;
      v = d_a;
      for (int s = 0; s < 4; s++) if (sch_e[s] < 256 * f) v = sch_v[s];
      return v;
   endfunction

   task automatic bus_op(input logic we, input logic [3:0] be, input logic [7:0] addr,
                         input logic [31:0] wd, output logic [33:0] resp);
      @(negedge clk_sys);
      bus_if.req_i   = 1'b1;
      bus_if.we_i    = we;
      bus_if.be_i    = be;
      bus_if.addr_i  = addr;
      bus_if.wdata_i = wd;
      @(negedge clk_sys);
      bus_if.req_i = 1'b0;
      bus_if.we_i  = 1'b0;
      resp = {bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o};
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be,
                     input logic exp_err);
      logic [33:0] r;
      bus_op(1'b1, be, addr, wd, r);
      chk($sformatf("wr_resp_%0h", addr), {254'd0, r[33:32]}, {254'd0, 1'b1, exp_err});
   endtask

   task automatic rd(input string tag, input logic [7:0] addr, input logic [31:0] exp_d,
                     input logic exp_e);
      logic [33:0] r;
      bus_op(1'b0, 4'hF, addr, 32'h0, r);
      chk(tag, {222'd0, r}, {222'd0, 1'b1, exp_e, exp_d});
   endtask

   initial begin
      logic [255:0]       obs;
      logic [255:0]       expv;
      logic [NumLeds-1:1] hi_acc;
      logic [33:0]        r1;
      logic [33:0]        r2;
      int                 k;
      int                 p;
      int                 f;
      int                 idx;
      logic [3:0]         be;
      logic [31:0]        wd;
`ifdef LED_PWM_BLINK_EN
      int                 bl;
`endif

      bus_if.req_i   = 1'b0;
      bus_if.we_i    = 1'b0;
      bus_if.be_i    = 4'h0;
      bus_if.addr_i  = 8'h0;
      bus_if.wdata_i = 32'h0;
      for (int i = 0; i < NumLeds; i++) dm[i] = 32'h0;

      // ---- Reset state ----
      repeat (2) @(negedge clk_sys);
      chk("rst_outputs", {220'd0, bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o, led_o},
          256'd0);
      bus_if.req_i = 1'b1;
      #1 chk("gnt_follows_req1", {255'd0, bus_if.gnt_o}, 256'd1);
      bus_if.req_i = 1'b0;
      #1 chk("gnt_follows_req0", {255'd0, bus_if.gnt_o}, 256'd0);
      @(negedge clk_sys);
      rst_sys_n = 1'b1;

      rd("rst_ctrl",  8'h00, 32'h0, 1'b0);
      rd("rst_presc", 8'h04, 32'h0, 1'b0);
      rd("rst_mode",  8'h08, 32'h0, 1'b0);
      rd("rst_blink", 8'h0C, 32'h0, 1'b0);
      rd("rst_duty0", 8'h40, 32'h0, 1'b0);
      chk("rst_led", {252'd0, led_o}, 256'd0);

      // ---- All LEDs on; output lags MODE and EN by one cycle ----
      wr(8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd("ctrl_rb", 8'h00, 32'h1, 1'b0);
      wr(8'h08, 32'hFFFF_FF55, 4'b0001, 1'b0);
      chk("led_mode_lag", {252'd0, led_o}, 256'd0);
      @(negedge clk_sys);
      chk("led_all_on", {252'd0, led_o}, 256'hF);
      rd("mode_rb", 8'h08, 32'h55, 1'b0);
      wr(8'h00, 32'h0, 4'hF, 1'b0);
      chk("led_en_lag", {252'd0, led_o}, 256'hF);
      @(negedge clk_sys);
      chk("led_en_off", {252'd0, led_o}, 256'h0);

      // ---- Byte enables and unimplemented bits ----
      wr(8'h04, 32'h0000_1234, 4'b0011, 1'b0);
      wr(8'h04, 32'hFFFF_ABFF, 4'b0010, 1'b0);
      rd("presc_be", 8'h04, 32'h0000_AB34, 1'b0);
      wr(8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0);
      rd("presc_width", 8'h04, 32'h0000_FFFF, 1'b0);
      wr(8'h04, 32'h0, 4'hF, 1'b0);

      // ---- Random DUTY register traffic against the byte-merge model ----
      for (int n = 0; n < 8; n++) begin
         idx = int'($urandom_range(0, NumLeds - 1));
         be  = 4'($urandom_range(0, 15));
         wd  = $urandom;
         wr(8'(8'h40 + 4 * idx), wd, be, 1'b0);
         dm[idx] = merge(dm[idx], wd, be) & 32'hFF;
         rd($sformatf("duty%0d_rand%0d", idx, n), 8'(8'h40 + 4 * idx), dm[idx], 1'b0);
      end

      // ---- Unmapped offsets ----
      for (int n = 0; n < 4; n++) begin
         idx = (n < 2) ? int'(8'h10 + 4 * $urandom_range(0, 11))
                       : int'(8'h50 + 4 * $urandom_range(0, 43));
         rd($sformatf("unmapped_%0h", idx), 8'(idx), 32'h0, 1'b1);
      end
      wr(8'h50, 32'hFFFF_FFFF, 4'hF, 1'b1);
      rd("unmapped_wr_nochg", 8'h40, dm[0], 1'b0);

      // ---- Read directly after write, back-to-back ----
      wd = $urandom;
      @(negedge clk_sys);
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.be_i = 4'hF;
      bus_if.addr_i = 8'h48; bus_if.wdata_i = wd;
      @(negedge clk_sys);
      r1 = {bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o};
      bus_if.we_i = 1'b0;
      @(negedge clk_sys);
      r2 = {bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o};
      bus_if.req_i = 1'b0;
      dm[2] = wd & 32'hFF;
      chk("b2b_wr_resp", {254'd0, r1[33:32]}, {254'd0, 2'b10});
      chk("b2b_raw", {222'd0, r2}, {222'd0, 2'b10, dm[2]});

      // ---- Back-to-back error responses ----
      @(negedge clk_sys);
      bus_if.req_i = 1'b1; bus_if.addr_i = 8'h50;
      @(negedge clk_sys);
      r1 = {bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o};
      bus_if.addr_i = 8'h10;
      @(negedge clk_sys);
      r2 = {bus_if.rvalid_o, bus_if.err_o, bus_if.rdata_o};
      bus_if.req_i = 1'b0;
      @(negedge clk_sys);
      chk("b2b_err_50", {222'd0, r1}, {222'd0, 2'b11, 32'h0});
      chk("b2b_err_10", {222'd0, r2}, {222'd0, 2'b11, 32'h0});
      chk("b2b_idle", {255'd0, bus_if.rvalid_o}, 256'd0);

      // ---- PWM with shadowed duty, PRESC=0 ----
      d_a    = 64;
      s_init = 0;  // shadows only ever captured zero duty so far
      sch_e[0] = 512 + int'($urandom_range(1, 254));  sch_v[0] = 192;
      sch_e[1] = 1024;                                sch_v[1] = int'($urandom_range(1, 254));
      sch_e[2] = 1280 + int'($urandom_range(1, 254)); sch_v[2] = 255;
      sch_e[3] = 1536 + int'($urandom_range(1, 254)); sch_v[3] = 0;
      wr(8'h40, 32'(d_a), 4'hF, 1'b0);
      wr(8'h08, 32'h02, 4'hF, 1'b0);
      wr(8'h00, 32'h1, 4'hF, 1'b0);
      hi_acc = '0;
      // Negedge k+2 after the EN request shows the LED computed from cycle k.
      for (int kk = 0; kk < 2304; kk++) begin
         @(negedge clk_sys);
         k = kk; p = k % 256; f = k / 256;
         obs[p]  = led_o[0];
         expv[p] = pwm_on(shadow_for(f), p);
         hi_acc |= led_o[NumLeds-1:1];
         bus_if.req_i = 1'b0;
         bus_if.we_i  = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (sch_e[s] == k + 2) begin
               bus_if.req_i = 1'b1; bus_if.we_i = 1'b1; bus_if.be_i = 4'hF;
               bus_if.addr_i = 8'h40; bus_if.wdata_i = 32'(sch_v[s]);
            end
         end
         if (p == 255) chk($sformatf("pwm_frame%0d", f), obs, expv);
      end
      bus_if.req_i = 1'b0;
      chk("pwm_other_leds", {{(256 - NumLeds + 1){1'b0}}, hi_acc}, 256'd0);

      // ---- Blink ----
      wr(8'h00, 32'h0, 4'hF, 1'b0);
`ifdef LED_PWM_BLINK_EN
      bl = int'($urandom_range(0, 2));
      wr(8'h0C, 32'(bl), 4'hF, 1'b0);
      rd("blink_rb", 8'h0C, 32'(bl), 1'b0);
`else
      wr(8'h0C, 32'h1, 4'hF, 1'b0);
      rd("blink_absent", 8'h0C, 32'h0, 1'b0);
`endif
      wr(8'h40, 32'hFF, 4'hF, 1'b0);
      wr(8'h08, 32'h03, 4'hF, 1'b0);
      wr(8'h00, 32'h1, 4'hF, 1'b0);
      hi_acc = '0;
      for (int kk = 0; kk < 1536; kk++) begin
         @(negedge clk_sys);
         k = kk; p = k % 256; f = k / 256;
         obs[p] = led_o[0];
`ifdef LED_PWM_BLINK_EN
         expv[p] = (((f / (bl + 1)) % 2) == 1) && pwm_on((f == 0) ? 0 : 255, p);
`else
         expv[p] = 1'b0;
`endif
         hi_acc |= led_o[NumLeds-1:1];
         if (p == 255) chk($sformatf("blink_frame%0d", f), obs, expv);
      end
      chk("blink_other_leds", {{(256 - NumLeds + 1){1'b0}}, hi_acc}, 256'd0);

      // ---- Reset during a pending response ----
      @(negedge clk_sys);
      bus_if.req_i = 1'b1; bus_if.we_i = 1'b0; bus_if.addr_i = 8'h00;
      @(posedge clk_sys);
      #1;
      rst_sys_n    = 1'b0;
      bus_if.req_i = 1'b0;
      #1 chk("rst_drop_rvalid", {255'd0, bus_if.rvalid_o}, 256'd0);
      @(negedge clk_sys);
      rst_sys_n = 1'b1;
      r1 = '0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk_sys);
         r1[0] = r1[0] | bus_if.rvalid_o;
      end
      chk("rst_no_late_rvalid", {255'd0, r1[0]}, 256'd0);
      chk("rst_led_off", {252'd0, led_o}, 256'd0);
      rd("rst_ctrl_cleared", 8'h00, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
